// File: rtl/seven_segment_mux.sv
// Multiplexed N-digit seven-segment driver with hex/decimal display,
// sequential double-dabble conversion, PWM dimming and selectable polarity.
module seven_segment_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int HEX          = 0,
    parameter int CLK_FREQ_MHZ = 125,
    parameter int DIGIT_US     = 1000,
    parameter int BRIGHT_BITS  = 4,
    parameter int ACTIVE_LOW   = 1,
    localparam int DATA_BITS   = (HEX == 1) ? 4 * NUM_DIGITS
                                            : $clog2(10 ** NUM_DIGITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_BITS-1:0]   data_in,
    input  logic                   data_valid,
    output logic                   busy,
    input  logic [NUM_DIGITS-1:0]  dp_in,
    input  logic                   blank_lz,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [NUM_DIGITS-1:0]  enable,
    output logic [7:0]             led_out
);

    localparam int DIGIT_CYCLES = CLK_FREQ_MHZ * DIGIT_US;
    localparam int SW  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW  = 4 * NUM_DIGITS;
    localparam bit INV = (ACTIVE_LOW == 1);

    logic [SW-1:0]          r_slot;
    logic [IW-1:0]          r_idx;
    logic [BRIGHT_BITS-1:0] r_pwm;
    logic [DW-1:0]          r_dig;
    logic [NUM_DIGITS-1:0]  r_dp;
    logic                   r_ovf;
    logic                   r_busy;
    logic [NUM_DIGITS-1:0]  r_en;
    logic [7:0]             r_led;

    logic [3:0]             w_nib;
    logic                   w_dpb;
    logic                   w_zero;
    logic                   w_blank;
    logic [6:0]             w_seg;
    logic                   w_lit;
    logic [7:0]             w_led;
    logic [NUM_DIGITS-1:0]  w_en;

    assign busy    = r_busy;
    assign enable  = r_en;
    assign led_out = r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
            r_idx  <= '0;
            r_pwm  <= '0;
        end else if (r_slot == SW'(DIGIT_CYCLES - 1)) begin
            r_slot <= '0;
            r_pwm  <= '0;
            r_idx  <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_slot <= r_slot + 1'b1;
            r_pwm  <= r_pwm + 1'b1;
        end
    end

    if (HEX == 1) begin : g_hex
        always_ff @(posedge clk) begin
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
            if (rst) begin
                r_dig <= '0;
                r_dp  <= '0;
            end else if (data_valid) begin
                r_dig <= data_in;
                r_dp  <= dp_in;
            end
        end
    end else begin : g_dec
        localparam int CW = $clog2(DATA_BITS + 1);
        localparam logic [DATA_BITS:0] LIMIT =
            (DATA_BITS + 1)'(10 ** NUM_DIGITS);

        logic [DATA_BITS-1:0]  r_shift;
        logic [DW-1:0]         r_bcd;
        logic [CW-1:0]         r_cnt;
        logic                  r_ovf_cap;
        logic [NUM_DIGITS-1:0] r_dp_cap;
        logic [DW-1:0]         w_adj;
        logic [DW-1:0]         w_bcd_nx;
        logic [DATA_BITS-1:0]  w_shift_nx;

        always_comb begin
            w_adj = '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5)
                                ? r_bcd[4*i +: 4] + 4'd3
                                : r_bcd[4*i +: 4];
            end
        end

        assign w_bcd_nx   = DW'({w_adj, r_shift[DATA_BITS-1]});
        assign w_shift_nx = DATA_BITS'({r_shift, 1'b0});

        // digits only change on the final iteration, so the old
        // value stays on the display during the whole conversion
        always_ff @(posedge clk) begin
            if (rst) begin
                r_busy    <= 1'b0;
                r_dig     <= '0;
                r_dp      <= '0;
                r_ovf     <= 1'b0;
                r_shift   <= '0;
                r_bcd     <= '0;
                r_cnt     <= '0;
                r_ovf_cap <= 1'b0;
                r_dp_cap  <= '0;
            end else if (!r_busy) begin
                if (data_valid) begin
                    r_shift   <= data_in;
                    r_bcd     <= '0;
                    r_cnt     <= CW'(DATA_BITS);
                    r_busy    <= 1'b1;
                    r_dp_cap  <= dp_in;
                    r_ovf_cap <= {1'b0, data_in} >= LIMIT;
                end
            end else begin
                r_shift <= w_shift_nx;
                r_bcd   <= w_bcd_nx;
                r_cnt   <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_dig  <= w_bcd_nx;
                    r_dp   <= r_dp_cap;
                    r_ovf  <= r_ovf_cap;
                end
            end
        end
    end

    always_comb begin
        w_nib   = '0;
        w_dpb   = 1'b0;
        w_blank = 1'b0;
        w_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero = w_zero & (r_dig[4*i +: 4] == 4'd0);
            if (r_idx == IW'(i)) begin
                w_nib   = r_dig[4*i +: 4];
                w_dpb   = r_dp[i];
                w_blank = blank_lz && w_zero && (i != 0);
            end
        end
    end

    always_comb begin
        case (w_nib)
            4'h0: w_seg = 7'b1111110;
            4'h1: w_seg = 7'b0110000;
            4'h2: w_seg = 7'b1101101;
            4'h3: w_seg = 7'b1111001;
            4'h4: w_seg = 7'b0110011;
            4'h5: w_seg = 7'b1011011;
            4'h6: w_seg = 7'b1011111;
            4'h7: w_seg = 7'b1110000;
            4'h8: w_seg = 7'b1111111;
            4'h9: w_seg = 7'b1111011;
            4'hA: w_seg = 7'b1110111;
            4'hB: w_seg = 7'b0011111;
            4'hC: w_seg = 7'b1001110;
            4'hD: w_seg = 7'b0111101;
            4'hE: w_seg = 7'b1001111;
            default: w_seg = 7'b1000111;
        endcase
        if (HEX != 1 && w_nib > 4'd9) w_seg = '0;
    end

    always_comb begin
        w_lit = (brightness == '1) || (r_pwm < brightness);
        if (r_ovf) w_led = 8'b0000_0010;
        else if (w_blank) w_led = {7'b0, w_dpb};
        else w_led = {w_seg, w_dpb};
        w_en = NUM_DIGITS'(1) << r_idx;
        if (!w_lit) begin
            w_en  = '0;
            w_led = '0;
        end
    end

    // both outputs share one register stage so digits never ghost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en  <= {NUM_DIGITS{INV}};
            r_led <= {8{INV}};
        end else begin
            r_en  <= w_en ^ {NUM_DIGITS{INV}};
            r_led <= w_led ^ {8{INV}};
        end
    end

endmodule
